// File: rtl/sd_ram_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sd_ram_loader_pkg
//  Description : Shared widths, FSM state encodings and address-strobe phase
//                encodings for the SD-to-cartridge-SRAM loader.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package sd_ram_loader_pkg;

    localparam int ADDR_W  = 15;
    localparam int LEN_W   = 16;

    // Loader FSM encodings
    localparam int STATE_W = 4;
    localparam logic [STATE_W-1:0] c_st_idle        = 4'd0;
    localparam logic [STATE_W-1:0] c_st_load_lo     = 4'd1;
    localparam logic [STATE_W-1:0] c_st_load_hi     = 4'd2;
    localparam logic [STATE_W-1:0] c_st_xfer        = 4'd3;
    localparam logic [STATE_W-1:0] c_st_wait_ack_hi = 4'd4;
    localparam logic [STATE_W-1:0] c_st_wait_ack_lo = 4'd5;
    localparam logic [STATE_W-1:0] c_st_push        = 4'd6;
    localparam logic [STATE_W-1:0] c_st_inc         = 4'd7;
    localparam logic [STATE_W-1:0] c_st_done        = 4'd8;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE        = c_st_idle,
        ST_LOAD_LO     = c_st_load_lo,
        ST_LOAD_HI     = c_st_load_hi,
        ST_XFER        = c_st_xfer,
        ST_WAIT_ACK_HI = c_st_wait_ack_hi,
        ST_WAIT_ACK_LO = c_st_wait_ack_lo,
        ST_PUSH        = c_st_push,
        ST_INC         = c_st_inc,
        ST_DONE        = c_st_done
    } state_t;

    // Address-strobe sequencer phase encodings
    localparam int PHASE_W = 2;
    localparam logic [PHASE_W-1:0] c_ph_idle  = 2'd0;
    localparam logic [PHASE_W-1:0] c_ph_setup = 2'd1;
    localparam logic [PHASE_W-1:0] c_ph_high  = 2'd2;
    localparam logic [PHASE_W-1:0] c_ph_hold  = 2'd3;

    typedef enum logic [PHASE_W-1:0] {
        PH_IDLE  = c_ph_idle,
        PH_SETUP = c_ph_setup,
        PH_HIGH  = c_ph_high,
        PH_HOLD  = c_ph_hold
    } phase_t;

    // The arbiter's high-address register is 7 bits wide; bit 7 is always 0.
    function automatic logic [7:0] addr_hi_byte(input logic [ADDR_W-1:0] a);
        return {1'b0, a[14:8]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/uc_addr_strobe.sv
`default_nettype none
// ============================================================================
//  Module      : uc_addr_strobe
//  Description : Generates one address-load/increment strobe toward the
//                cart/SRAM arbiter: SETUP, HIGH, HOLD phases, each
//                STROBE_CYCLES clocks. set_addr_* and uc_dout are latched at
//                start and held through all three phases; strobe_addr is
//                high only during HIGH.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                start               - begin a strobe (ignored while busy)
//                lo, hi, data        - select lines / byte to present
//                busy                - a strobe sequence is in progress
//                done                - one-cycle pulse after HOLD ends
//                strobe_addr         - strobe to arbiter
//                set_addr_lo/hi      - address-load selects
//                uc_dout             - byte presented during the strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module uc_addr_strobe
    import sd_ram_loader_pkg::*;
#(
    parameter int STROBE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       lo,
    input  logic       hi,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       strobe_addr,
    output logic       set_addr_lo,
    output logic       set_addr_hi,
    output logic [7:0] uc_dout
);

    localparam int                 c_cnt_w    = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(STROBE_CYCLES - 1);

    phase_t             r_phase_q,  w_phase_d;
    logic [c_cnt_w-1:0] r_cnt_q,    w_cnt_d;
    logic               r_lo_q,     w_lo_d;
    logic               r_hi_q,     w_hi_d;
    logic [7:0]         r_dout_q,   w_dout_d;
    logic               r_done_q,   w_done_d;
    logic               r_strobe_q, w_strobe_d;

    always_comb begin
        w_phase_d = r_phase_q;
        w_cnt_d   = r_cnt_q;
        w_lo_d    = r_lo_q;
        w_hi_d    = r_hi_q;
        w_dout_d  = r_dout_q;
        w_done_d  = 1'b0;
        case (r_phase_q)
            PH_IDLE: begin
                if (start) begin
                    w_phase_d = PH_SETUP;
                    w_cnt_d   = c_cnt_last;
                    w_lo_d    = lo;
                    w_hi_d    = hi;
                    w_dout_d  = data;
                end
            end
            PH_SETUP, PH_HIGH: begin
                if (r_cnt_q == '0) begin
                    w_phase_d = (r_phase_q == PH_SETUP) ? PH_HIGH : PH_HOLD;
                    w_cnt_d   = c_cnt_last;
                end else begin
                    w_cnt_d   = r_cnt_q - 1'b1;
                end
            end
            PH_HOLD: begin
                if (r_cnt_q == '0) begin
                    w_phase_d = PH_IDLE;
                    w_lo_d    = 1'b0;
                    w_hi_d    = 1'b0;
                    w_done_d  = 1'b1;
                end else begin
                    w_cnt_d   = r_cnt_q - 1'b1;
                end
            end
            default: w_phase_d = PH_IDLE;
        endcase
        w_strobe_d = (w_phase_d == PH_HIGH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase_q  <= PH_IDLE;
            r_cnt_q    <= '0;
            r_lo_q     <= 1'b0;
            r_hi_q     <= 1'b0;
            r_dout_q   <= 8'h00;
            r_done_q   <= 1'b0;
            r_strobe_q <= 1'b0;
        end else begin
            r_phase_q  <= w_phase_d;
            r_cnt_q    <= w_cnt_d;
            r_lo_q     <= w_lo_d;
            r_hi_q     <= w_hi_d;
            r_dout_q   <= w_dout_d;
            r_done_q   <= w_done_d;
            r_strobe_q <= w_strobe_d;
        end
    end

    assign busy        = (r_phase_q != PH_IDLE);
    assign done        = r_done_q;
    assign strobe_addr = r_strobe_q;
    assign set_addr_lo = r_lo_q;
    assign set_addr_hi = r_hi_q;
    assign uc_dout     = r_dout_q;

endmodule
`default_nettype wire

// File: rtl/sd_ram_loader.sv
`default_nettype none
// ============================================================================
//  Module      : sd_ram_loader
//  Description : Bus master for the microcontroller port of the cart/SRAM
//                arbiter. Loads the SRAM address once per command, then moves
//                cmd_len bytes between the byte streams and SRAM using the
//                uc_write/uc_read/uc_ack four-phase handshake, stepping the
//                arbiter address with increment strobes.
//  Ports       : clk, rst                   - clock, sync active-high reset
//                cmd_*                      - command (valid/ready)
//                in_*                       - write stream into SRAM
//                out_*                      - read stream out of SRAM
//                busy, done, err            - status (err sticky on timeout)
//                uc_dout, uc_oe, uc_din     - arbiter data bus
//                uc_write, uc_read, uc_ack  - arbiter handshake
//                set_addr_lo/hi, strobe_addr- arbiter address load protocol
//  Revision    : 1.0 - initial release
// ============================================================================
module sd_ram_loader
    import sd_ram_loader_pkg::*;
#(
    parameter int STROBE_CYCLES = 2,
    parameter int ACK_TIMEOUT   = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [7:0]        uc_dout,
    output logic              uc_oe,
    input  logic [7:0]        uc_din,
    output logic              uc_write,
    output logic              uc_read,
    input  logic              uc_ack,
    output logic              set_addr_lo,
    output logic              set_addr_hi,
    output logic              strobe_addr
);

    localparam int                c_to_w    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'(ACK_TIMEOUT - 1);

    state_t            r_state_q,     w_state_d;
    logic              r_write_q,     w_write_d;
    logic [ADDR_W-1:0] r_addr_q,      w_addr_d;
    logic [LEN_W-1:0]  r_rem_q,       w_rem_d;
    logic [7:0]        r_wdata_q,     w_wdata_d;
    logic [7:0]        r_rdata_q,     w_rdata_d;
    logic              r_inc_wait_q,  w_inc_wait_d;
    logic [c_to_w-1:0] r_tcnt_q,      w_tcnt_d;
    logic              r_cmd_ready_q, w_cmd_ready_d;
    logic              r_in_ready_q,  w_in_ready_d;
    logic              r_out_valid_q, w_out_valid_d;
    logic              r_busy_q,      w_busy_d;
    logic              r_done_q,      w_done_d;
    logic              r_err_q,       w_err_d;
    logic              r_oe_q,        w_oe_d;
    logic              r_uc_write_q,  w_uc_write_d;
    logic              r_uc_read_q,   w_uc_read_d;
    logic              r_strb_start_q, w_strb_start_d;

    // uc_ack comes from another clock domain inside the arbiter.
    logic r_ack_meta_q, r_ack_sync_q;

    logic       w_strb_lo, w_strb_hi, w_strb_busy, w_strb_done;
    logic [7:0] w_strb_data, w_strb_dout;

    // Increment strobes (INC state) present lo=hi=0 and data 0.
    assign w_strb_lo   = (r_state_q == ST_LOAD_LO);
    assign w_strb_hi   = (r_state_q == ST_LOAD_HI);
    assign w_strb_data = w_strb_lo ? r_addr_q[7:0] :
                         w_strb_hi ? addr_hi_byte(r_addr_q) : 8'h00;

    uc_addr_strobe #(
        .STROBE_CYCLES (STROBE_CYCLES)
    ) u_strobe (
        .clk         (clk),
        .rst         (rst),
        .start       (r_strb_start_q),
        .lo          (w_strb_lo),
        .hi          (w_strb_hi),
        .data        (w_strb_data),
        .busy        (w_strb_busy),
        .done        (w_strb_done),
        .strobe_addr (strobe_addr),
        .set_addr_lo (set_addr_lo),
        .set_addr_hi (set_addr_hi),
        .uc_dout     (w_strb_dout)
    );

    always_comb begin
        w_state_d      = r_state_q;
        w_write_d      = r_write_q;
        w_addr_d       = r_addr_q;
        w_rem_d        = r_rem_q;
        w_wdata_d      = r_wdata_q;
        w_rdata_d      = r_rdata_q;
        w_inc_wait_d   = r_inc_wait_q;
        w_tcnt_d       = '0;
        w_cmd_ready_d  = r_cmd_ready_q;
        w_in_ready_d   = r_in_ready_q;
        w_out_valid_d  = r_out_valid_q;
        w_busy_d       = r_busy_q;
        w_done_d       = 1'b0;
        w_err_d        = r_err_q;
        w_oe_d         = r_oe_q;
        w_uc_write_d   = r_uc_write_q;
        w_uc_read_d    = r_uc_read_q;
        w_strb_start_d = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_write_d     = cmd_write;
                    w_addr_d      = cmd_addr;
                    w_rem_d       = cmd_len;
                    w_err_d       = 1'b0;
                    w_cmd_ready_d = 1'b0;
                    w_busy_d      = 1'b1;
                    if (cmd_len == '0) begin
                        w_state_d = ST_DONE;
                        w_done_d  = 1'b1;
                    end else begin
                        w_state_d      = ST_LOAD_LO;
                        w_oe_d         = 1'b1;
                        w_strb_start_d = 1'b1;
                    end
                end
            end
            ST_LOAD_LO: begin
                if (w_strb_done) begin
                    w_state_d      = ST_LOAD_HI;
                    w_strb_start_d = 1'b1;
                end
            end
            ST_LOAD_HI: begin
                if (w_strb_done) begin
                    w_state_d    = ST_XFER;
                    w_oe_d       = 1'b0;
                    w_in_ready_d = r_write_q;
                end
            end
            ST_XFER: begin
                if (r_write_q) begin
                    if (in_valid && r_in_ready_q) begin
                        w_wdata_d    = in_data;
                        w_oe_d       = 1'b1;
                        w_uc_write_d = 1'b1;
                        w_in_ready_d = 1'b0;
                        w_state_d    = ST_WAIT_ACK_HI;
                    end
                end else begin
                    w_oe_d      = 1'b0;
                    w_uc_read_d = 1'b1;
                    w_state_d   = ST_WAIT_ACK_HI;
                end
            end
            ST_WAIT_ACK_HI, ST_WAIT_ACK_LO: begin
                if ((r_state_q == ST_WAIT_ACK_HI) && r_ack_sync_q) begin
                    // The arbiter keeps uc_din valid while ack is high.
                    if (!r_write_q) begin
                        w_rdata_d = uc_din;
                    end
                    w_uc_write_d = 1'b0;
                    w_uc_read_d  = 1'b0;
                    w_state_d    = ST_WAIT_ACK_LO;
                end else if ((r_state_q == ST_WAIT_ACK_LO) && !r_ack_sync_q) begin
                    w_oe_d = 1'b0;
                    if (r_write_q) begin
                        w_state_d = ST_INC;
                    end else begin
                        w_out_valid_d = 1'b1;
                        w_state_d     = ST_PUSH;
                    end
                end else if (r_tcnt_q == c_to_last) begin
                    w_err_d      = 1'b1;
                    w_uc_write_d = 1'b0;
                    w_uc_read_d  = 1'b0;
                    w_oe_d       = 1'b0;
                    w_done_d     = 1'b1;
                    w_state_d    = ST_DONE;
                end else begin
                    w_tcnt_d = r_tcnt_q + 1'b1;
                end
            end
            ST_PUSH: begin
                if (out_ready) begin
                    w_out_valid_d = 1'b0;
                    w_state_d     = ST_INC;
                end
            end
            ST_INC: begin
                // First cycle decides; if bytes remain, wait for the
                // increment strobe to finish before the next transfer.
                if (!r_inc_wait_q) begin
                    w_rem_d = r_rem_q - 1'b1;
                    if (r_rem_q == LEN_W'(1)) begin
                        w_done_d  = 1'b1;
                        w_state_d = ST_DONE;
                    end else begin
                        w_strb_start_d = 1'b1;
                        w_inc_wait_d   = 1'b1;
                    end
                end else if (w_strb_done) begin
                    w_inc_wait_d = 1'b0;
                    w_in_ready_d = r_write_q;
                    w_state_d    = ST_XFER;
                end
            end
            ST_DONE: begin
                w_state_d     = ST_IDLE;
                w_cmd_ready_d = 1'b1;
                w_busy_d      = 1'b0;
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= ST_IDLE;
            r_write_q      <= 1'b0;
            r_addr_q       <= '0;
            r_rem_q        <= '0;
            r_wdata_q      <= 8'h00;
            r_rdata_q      <= 8'h00;
            r_inc_wait_q   <= 1'b0;
            r_tcnt_q       <= '0;
            r_cmd_ready_q  <= 1'b1;
            r_in_ready_q   <= 1'b0;
            r_out_valid_q  <= 1'b0;
            r_busy_q       <= 1'b0;
            r_done_q       <= 1'b0;
            r_err_q        <= 1'b0;
            r_oe_q         <= 1'b0;
            r_uc_write_q   <= 1'b0;
            r_uc_read_q    <= 1'b0;
            r_strb_start_q <= 1'b0;
            r_ack_meta_q   <= 1'b0;
            r_ack_sync_q   <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_write_q      <= w_write_d;
            r_addr_q       <= w_addr_d;
            r_rem_q        <= w_rem_d;
            r_wdata_q      <= w_wdata_d;
            r_rdata_q      <= w_rdata_d;
            r_inc_wait_q   <= w_inc_wait_d;
            r_tcnt_q       <= w_tcnt_d;
            r_cmd_ready_q  <= w_cmd_ready_d;
            r_in_ready_q   <= w_in_ready_d;
            r_out_valid_q  <= w_out_valid_d;
            r_busy_q       <= w_busy_d;
            r_done_q       <= w_done_d;
            r_err_q        <= w_err_d;
            r_oe_q         <= w_oe_d;
            r_uc_write_q   <= w_uc_write_d;
            r_uc_read_q    <= w_uc_read_d;
            r_strb_start_q <= w_strb_start_d;
            r_ack_meta_q   <= uc_ack;
            r_ack_sync_q   <= r_ack_meta_q;
        end
    end

    assign cmd_ready = r_cmd_ready_q;
    assign in_ready  = r_in_ready_q;
    assign out_data  = r_rdata_q;
    assign out_valid = r_out_valid_q;
    assign busy      = r_busy_q;
    assign done      = r_done_q;
    assign err       = r_err_q;
    assign uc_oe     = r_oe_q;
    assign uc_write  = r_uc_write_q;
    assign uc_read   = r_uc_read_q;
    // Strobe byte while a strobe runs, otherwise the latched write byte.
    assign uc_dout   = w_strb_busy ? w_strb_dout : r_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_ram_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sd_ram_loader
//  Description : Self-checking bench for sd_ram_loader. An arbiter/SRAM model
//                answers the address-strobe and four-phase handshake; a
//                reference memory and expected-output queue hold what the
//                loader must produce.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_ram_loader;

    localparam int STROBE_CYCLES = 2;
    localparam int ACK_TIMEOUT   = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [14:0] cmd_addr = '0;
    logic [15:0] cmd_len = '0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0, in_ready;
    logic [7:0]  out_data;
    logic        out_valid, out_ready = 1'b0;
    logic        busy, done, err;
    logic [7:0]  uc_dout, uc_din = '0;
    logic        uc_oe, uc_write, uc_read, uc_ack = 1'b0;
    logic        set_addr_lo, set_addr_hi, strobe_addr;

    always #5 clk = ~clk;

    sd_ram_loader #(.STROBE_CYCLES(STROBE_CYCLES), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .err(err), .uc_dout(uc_dout), .uc_oe(uc_oe),
        .uc_din(uc_din), .uc_write(uc_write), .uc_read(uc_read), .uc_ack(uc_ack),
        .set_addr_lo(set_addr_lo), .set_addr_hi(set_addr_hi), .strobe_addr(strobe_addr)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0]  mem     [0:32767];   // arbiter-side SRAM
    logic [7:0]  ref_mem [0:32767];   // what SRAM must contain
    logic [7:0]  wbuf    [0:15];
    logic [14:0] arb_addr = '0;
    int  n_strb = 0, n_req = 0, done_cnt = 0;
    bit  no_ack = 1'b0;
    int  fixed_dly = 0, ack_dly = 3, req_cnt = 0;
    int  wr_run = 0, last_wr_run = 0;
    logic [7:0] strb_data[$];
    logic [1:0] strb_sel[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic       prev_strobe = 0, prev_write = 0, prev_read = 0, prev_ov = 0, prev_or = 0;
    logic [7:0] prev_dout = 0, prev_od = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Arbiter model and per-cycle output checks, sampled mid-cycle.
    always @(negedge clk) begin
        if (uc_write || uc_read || strobe_addr)
            check("wr_rd_exclusive", {31'd0, uc_write & uc_read}, 0);
        if (uc_write && prev_write) check("dout_stable_write", uc_dout, prev_dout);
        if (strobe_addr && prev_strobe) check("dout_stable_strobe", uc_dout, prev_dout);
        if (uc_write) check("oe_during_write", uc_oe, 1);
        if (uc_read) begin
            check("oe_during_read", uc_oe, 0);
            check("read_while_out_pending", out_valid, 0);
        end
        if (out_valid && prev_ov && !prev_or) check("out_stall_stable", out_data, prev_od);
        if (out_valid && out_ready) begin
            got_q.push_back(out_data);
            if (exp_q.size() == 0) check("out_unexpected", 1, 0);
            else check("out_data", out_data, exp_q.pop_front());
        end
        if (done) done_cnt++;

        if (strobe_addr && !prev_strobe) begin
            n_strb++;
            strb_sel.push_back({set_addr_hi, set_addr_lo});
            strb_data.push_back(uc_dout);
            if (set_addr_lo)      arb_addr[7:0]  = uc_dout;
            else if (set_addr_hi) arb_addr[14:8] = uc_dout[6:0];
            else                  arb_addr       = arb_addr + 15'd1;
        end
        if ((uc_write && !prev_write) || (uc_read && !prev_read)) n_req++;
        if (uc_write) wr_run++;
        else if (prev_write) begin last_wr_run = wr_run; wr_run = 0; end

        if (!uc_ack) begin
            if ((uc_write || uc_read) && !no_ack) begin
                req_cnt++;
                if (req_cnt >= ack_dly) begin
                    uc_ack = 1'b1;
                    if (uc_write) mem[arb_addr] = uc_dout;
                    else          uc_din = mem[arb_addr];
                end
            end else begin
                req_cnt = 0;
                uc_din  = 8'($urandom);
            end
        end else if (!uc_write && !uc_read) begin
            uc_ack  = 1'b0;
            req_cnt = 0;
            ack_dly = (fixed_dly > 0) ? fixed_dly : int'($urandom_range(1, 8));
        end

        prev_strobe = strobe_addr; prev_write = uc_write; prev_read = uc_read;
        prev_ov = out_valid; prev_or = out_ready; prev_dout = uc_dout; prev_od = out_data;
    end

    // Issue one command and drive its streams until done (bounded).
    task automatic do_cmd(input bit wr, input logic [14:0] addr, input int len,
                          input int hold, input bit exp_err);
        int  widx = 0, cyc = 0, d0, stall = 0;
        bit  rdy_now = 0, take;
        cmd_write = wr; cmd_addr = addr; cmd_len = 16'(len); cmd_valid = 1'b1;
        if (!exp_err) begin
            for (int i = 0; i < len; i++) begin
                if (wr) ref_mem[15'(addr + 15'(i))] = wbuf[i];
                else    exp_q.push_back(ref_mem[15'(addr + 15'(i))]);
            end
        end
        forever begin
            rdy_now = cmd_ready;
            @(posedge clk); #1; cyc++;
            if (rdy_now || cyc > 100) break;
        end
        cmd_valid = 1'b0;
        if (!rdy_now) check("cmd_accept_timeout", 0, 1);
        check("err_cleared_on_accept", err, 0);
        if (len == 0) check("len0_done_next_cycle", done, 1);
        d0 = done_cnt;
        cyc = 0;
        while (done_cnt == d0 && cyc < 5000) begin
            if (wr && widx < len && !in_valid && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1; in_data = wbuf[widx];
            end
            if (hold > 0) out_ready = (stall >= hold);
            else          out_ready = ($urandom_range(0, 3) != 0);
            if (out_valid && !out_ready) stall++;
            take = in_valid && in_ready;
            @(posedge clk); #1; cyc++;
            if (take) begin widx++; in_valid = 1'b0; end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        if (done_cnt == d0) check("done_timeout", 0, 1);
        check("done_one_cycle", done, 0);
        check("err_flag", err, {31'd0, exp_err});
        @(posedge clk); #1;
        check("done_pulse_count", done_cnt, d0 + 1);
        check("out_queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Common post-checks for a command that completed normally.
    task automatic post_ok(input logic [14:0] addr, input int len, input int s0, input int r0);
        check("strobe_count", n_strb - s0, len + 1);
        check("request_count", n_req - r0, len);
        check("final_arb_addr", arb_addr, 15'(addr + 15'(len - 1)));
        for (int i = 0; i < len; i++)
            check("sram_contents", mem[15'(addr + 15'(i))], ref_mem[15'(addr + 15'(i))]);
    endtask

    int s0, r0, d0, cyc;
    logic [14:0] ra;
    int rl;
    bit rw;

    initial begin
        for (int i = 0; i < 32768; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_outputs",
              {busy, done, err, uc_oe, uc_write, uc_read, strobe_addr, set_addr_lo, set_addr_hi,
               in_ready, out_valid}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Write 0x1234 len 3, arbiter acks after 4 cycles.
        fixed_dly = 4; ack_dly = 4;
        wbuf[0] = 8'hA5; wbuf[1] = 8'h5A; wbuf[2] = 8'hFF;
        strb_sel.delete(); strb_data.delete();
        s0 = n_strb; r0 = n_req;
        do_cmd(1'b1, 15'h1234, 3, 0, 1'b0);
        post_ok(15'h1234, 3, s0, r0);
        check("w1_strobe0_sel", strb_sel[0], 2'b01);
        check("w1_strobe0_data", strb_data[0], 8'h34);
        check("w1_strobe1_sel", strb_sel[1], 2'b10);
        check("w1_strobe1_data", strb_data[1], 8'h12);
        check("w1_strobe2_sel", strb_sel[2], 2'b00);
        check("w1_strobe3_sel", strb_sel[3], 2'b00);
        check("w1_mem_1234", mem[15'h1234], 8'hA5);
        check("w1_mem_1235", mem[15'h1235], 8'h5A);
        check("w1_mem_1236", mem[15'h1236], 8'hFF);
        fixed_dly = 0;

        // Read across the top of SRAM.
        mem[15'h7FFE] = 8'h11; mem[15'h7FFF] = 8'h22; mem[15'h0000] = 8'h33;
        ref_mem[15'h7FFE] = 8'h11; ref_mem[15'h7FFF] = 8'h22; ref_mem[15'h0000] = 8'h33;
        got_q.delete();
        s0 = n_strb; r0 = n_req;
        do_cmd(1'b0, 15'h7FFE, 3, 0, 1'b0);
        post_ok(15'h7FFE, 3, s0, r0);
        check("wrap_out_count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("wrap_out0", got_q[0], 8'h11);
            check("wrap_out1", got_q[1], 8'h22);
            check("wrap_out2", got_q[2], 8'h33);
        end
        check("wrap_arb_addr", arb_addr, 15'h0000);

        // Zero length: no bus activity.
        s0 = n_strb; r0 = n_req;
        do_cmd(1'b1, 15'h0400, 0, 0, 1'b0);
        check("len0_strobes", n_strb - s0, 0);
        check("len0_requests", n_req - r0, 0);

        // Arbiter never acks.
        no_ack = 1'b1;
        wbuf[0] = 8'h3C; wbuf[1] = 8'hC3;
        do_cmd(1'b1, 15'h0100, 2, 0, 1'b1);
        check("timeout_write_cycles", last_wr_run, ACK_TIMEOUT);
        check("timeout_write_dropped", uc_write, 0);
        check("timeout_oe_dropped", uc_oe, 0);
        no_ack = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Read with consumer stalled 50 cycles on the first byte; also clears err.
        s0 = n_strb; r0 = n_req;
        do_cmd(1'b0, 15'h2000, 2, 50, 1'b0);
        post_ok(15'h2000, 2, s0, r0);

        // Reset while a write request is outstanding.
        fixed_dly = 4; ack_dly = 4;
        cmd_write = 1'b1; cmd_addr = 15'h0500; cmd_len = 16'd4; cmd_valid = 1'b1;
        in_valid = 1'b1; in_data = 8'h77;
        cyc = 0;
        while (!uc_write && cyc < 200) begin
            @(posedge clk); #1; cyc++;
            if (!cmd_ready) cmd_valid = 1'b0;
        end
        check("rst_reached_write", uc_write, 1);
        d0 = done_cnt;
        rst = 1'b1; in_valid = 1'b0; cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_uc_write", uc_write, 0);
        check("rst_uc_oe", uc_oe, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("rst_no_done", done_cnt, d0);
        check("rst_ack_low", uc_ack, 0);
        fixed_dly = 0;

        // Randomised commands.
        for (int k = 0; k < 10; k++) begin
            rw = 1'($urandom_range(0, 1));
            ra = (k % 3 == 0) ? 15'(15'h7FFC + 15'($urandom_range(0, 3))) : 15'($urandom);
            rl = int'($urandom_range(1, 6));
            for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
            s0 = n_strb; r0 = n_req;
            do_cmd(rw, ra, rl, 0, 1'b0);
            post_ok(ra, rl, s0, r0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        check("global_time_limit", 0, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
